store_narrow_unit: RTL and testbench
====================================

// Module: store_narrow_unit
// PURPOSE
//   Store-path counterpart of the immediate/load sign-extension unit: narrows 32-bit register data to byte/half/word,
//   checks the narrowing is lossless (inverse of sign/zero extension), places it on the correct byte lanes and
//   buffers the write for the data memory port. Sits between the datapath store stage and data memory.
// PARAMETERS
//   DEPTH  4   write-buffer entries; power of 2, >=2
//   AW     32  byte-address width
// PORTS
//   clk           in   1     rising-edge clock
//   rst_n         in   1     asynchronous reset, active-low
//   req_valid     in   1     store request present
//   req_ready     out  1     unit can accept a request this cycle
//   req_addr      in   AW    byte address
//   req_data      in   32    register data to store
//   req_size      in   2     00 byte, 01 half, 10 word, 11 reserved
//   req_signed    in   1     1: lossless check as signed, 0: as unsigned
//   mem_valid     out  1     write presented to memory
//   mem_ready     in   1     memory accepts write
//   mem_addr      out  AW    word-aligned address {req_addr[AW-1:2],2'b00}
//   mem_wdata     out  32    lane-replicated data
//   mem_be        out  4     byte enables
//   trunc_err     out  1     1-cycle pulse: accepted store lost significant bits
//   misalign_err  out  1     1-cycle pulse: accepted request misaligned or size 11
//   count         out  clog2(DEPTH)+1  buffered entries
// BEHAVIOUR
//   - Reset (async, any cycle): buffer flushed, pointers 0; req_ready=1, mem_valid=0, mem_addr/mem_wdata/mem_be=0,
//     trunc_err=0, misalign_err=0, count=0. In-flight write dropped; mem_valid falls without waiting for mem_ready.
//   - req_ready = (count != DEPTH); no same-cycle pass-through when full, even if a dequeue occurs.
//   - Accept = req_valid & req_ready. Accepted, aligned request enqueued at that edge; count+1.
//   - Alignment: half needs addr[0]=0, word needs addr[1:0]=00, size 11 always illegal. Illegal request is accepted,
//     NOT enqueued, misalign_err=1 the following cycle; no trunc_err for it.
//   - Lossless check (size byte n=8, half n=16; word never errs): signed -> data[31:n-1] all equal;
//     unsigned -> data[31:n]==0. Failure: store still performed with low n bits, trunc_err=1 next cycle.
//   - Lane placement, k=addr[1:0]: byte -> wdata={4{d[7:0]}}, be=4'b0001<<k; half -> wdata={2{d[15:0]}},
//     be=addr[1]?1100:0011; word -> wdata=d, be=1111.
//   - Output registered from buffer head: request accepted into empty buffer at edge N shows mem_valid=1 after edge N
//     (1-cycle latency). Payload stable while mem_valid & !mem_ready. Dequeue on mem_valid & mem_ready; next entry
//     (if any) presented next cycle with no bubble. Strict FIFO order.
//   - Simultaneous accept+dequeue: count unchanged. Pointers wrap modulo DEPTH.
//   - mem_valid = (count!=0); count never exceeds DEPTH or underflows.
// STRUCTURE
//   - Shared package store_pkg: SIZE_BYTE/HALF/WORD/RSVD encodings, BE_* patterns, entry struct {addr,wdata,be}.
//   - Sub-module store_fifo (DEPTH x entry, valid/ready both sides, count output); narrowing, lossless check,
//     alignment check and lane placement are combinational in the top, error pulses registered.
// TESTING
//   - Reset: hold rst_n=0 mid-burst with 3 entries -> all outputs 0, req_ready=1, count=0 immediately.
//   - Byte signed: addr=0x1003 data=0xFFFFFF80 size=00 signed=1 -> mem_addr=0x1000, wdata=0x80808080, be=1000,
//     trunc_err=0; data=0x00000180 -> wdata=0x80808080, trunc_err pulse.
//   - Half unsigned: addr=0x2002 data=0x0001ABCD size=01 signed=0 -> be=1100, wdata=0xABCDABCD, trunc_err pulse;
//     addr=0x2001 -> misalign_err pulse, nothing written, count unchanged.
//   - Backpressure: mem_ready=0, push 4 words -> count=4, req_ready=0, 5th held; mem_ready=1 -> drained in order,
//     one per cycle, payload stable while stalled.
//   - Simultaneous: count=2, accept+dequeue same edge -> count=2; size=11 at any addr -> misalign_err only.

Source files
------------

// File: rtl/store_pkg.sv
// Shared encodings and helpers for the store narrowing path: access sizes, byte-enable
// patterns, the lane payload and the lossless-narrowing / lane-placement functions.
package store_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // Data-side part of a buffered write; the address is added by the top, whose width is a parameter.
  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  be;
  } lane_t;

  // Narrowing is lossless when re-extending the low n bits reproduces the register value.
  function automatic logic is_lossless(size_e size, logic sgn, logic [31:0] d);
    case (size)
      SIZE_BYTE: return sgn ? (&d[31:7] | ~|d[31:7]) : ~|d[31:8];
      SIZE_HALF: return sgn ? (&d[31:15] | ~|d[31:15]) : ~|d[31:16];
      default:   return 1'b1;
    endcase
  endfunction

  function automatic lane_t place_lanes(size_e size, logic [1:0] k, logic [31:0] d);
    lane_t r;
    r = '0;
    case (size)
      SIZE_BYTE: begin
        r.wdata = {4{d[7:0]}};
        r.be    = BE_BYTE << k;
      end
      SIZE_HALF: begin
        r.wdata = {2{d[15:0]}};
        r.be    = k[1] ? BE_HALF_HI : BE_HALF_LO;
      end
      SIZE_WORD: begin
        r.wdata = d;
        r.be    = BE_WORD;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Write buffer: DEPTH-entry FIFO with valid/ready on both sides; the head entry is
// presented straight from storage so a write into an empty buffer is visible next cycle.
module store_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  entry_t        in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output entry_t        out_data,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Empty buffer shows an all-zero payload, so storage itself needs no reset.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store path: narrows register data to byte/half/word, flags lossy narrowing and misalignment,
// places data on byte lanes and buffers writes for the data memory port.
module store_narrow_unit
  import store_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  AW    = 32,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_data,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  output logic          trunc_err,
  output logic          misalign_err,
  output logic [CW-1:0] count
);

  typedef struct packed {
    logic [AW-1:0] addr;
    lane_t         lane;
  } entry_t;

  size_e  size;
  logic   accept;
  logic   aligned;
  logic   lossless;
  entry_t new_entry;
  entry_t head;

  assign size     = size_e'(req_size);
  assign accept   = req_valid & req_ready;
  assign lossless = is_lossless(size, req_signed, req_data);

  // NOTE: default assigned first so every path through the case drives aligned (no latch).
  always_comb begin
    aligned = 1'b0;
    case (size)
      SIZE_BYTE: aligned = 1'b1;
      SIZE_HALF: aligned = ~req_addr[0];
      SIZE_WORD: aligned = (req_addr[1:0] == 2'b00);
      default:   aligned = 1'b0;
    endcase
  end

  assign new_entry.addr = {req_addr[AW-1:2], 2'b00};
  assign new_entry.lane = place_lanes(size, req_addr[1:0], req_data);

  // Misaligned requests are consumed (req_ready is independent of legality) but never enqueued.
  store_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (req_valid & aligned),
    .in_ready  (req_ready),
    .in_data   (new_entry),
    .out_valid (mem_valid),
    .out_ready (mem_ready),
    .out_data  (head),
    .count     (count)
  );

  assign mem_addr  = head.addr;
  assign mem_wdata = head.lane.wdata;
  assign mem_be    = head.lane.be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trunc_err    <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      trunc_err    <= accept & aligned & ~lossless;
      misalign_err <= accept & ~aligned;
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit: a queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_store_narrow_unit;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_data = '0;
  logic [1:0]    req_size = '0;
  logic          req_signed = 1'b0;
  logic          mem_valid;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          trunc_err;
  logic          misalign_err;
  logic [CW-1:0] count;

  store_narrow_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .trunc_err    (trunc_err),
    .misalign_err (misalign_err),
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t q[$];
  bit   exp_trunc = 1'b0;
  bit   exp_mis   = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: value must fit in n bits as a signed or unsigned number.
  function automatic bit model_lossless(int size, bit sgn, logic [31:0] d);
    int     n;
    longint v;
    if (size == 2) return 1'b1;
    n = (size == 0) ? 8 : 16;
    if (sgn) begin
      v = longint'($signed(d));
      return (v >= -(longint'(1) << (n - 1))) && (v < (longint'(1) << (n - 1)));
    end
    return {32'b0, d} < (longint'(1) << n);
  endfunction

  function automatic bit model_legal(int size, logic [31:0] a);
    if (size == 3) return 1'b0;
    if (size == 1) return (a % 2) == 0;
    if (size == 2) return (a % 4) == 0;
    return 1'b1;
  endfunction

  function automatic exp_t model_entry(int size, logic [31:0] a, logic [31:0] d);
    exp_t e;
    int   k;
    k       = int'(a % 4);
    e.addr  = a - (a % 4);
    if (size == 0) begin
      e.wdata = (d % 256) * 32'h0101_0101;
      e.be    = 4'(1 << k);
    end else if (size == 1) begin
      e.wdata = (d % 65536) * 32'h0001_0001;
      e.be    = (k >= 2) ? 4'hC : 4'h3;
    end else begin
      e.wdata = d;
      e.be    = 4'hF;
    end
    return e;
  endfunction

  task automatic compare_outputs();
    check("req_ready", 64'(req_ready), 64'(q.size() != DEPTH));
    check("mem_valid", 64'(mem_valid), 64'(q.size() != 0));
    check("count", 64'(count), 64'(q.size()));
    check("trunc_err", 64'(trunc_err), 64'(exp_trunc));
    check("misalign_err", 64'(misalign_err), 64'(exp_mis));
    if (q.size() != 0) begin
      check("mem_addr", 64'(mem_addr), 64'(q[0].addr));
      check("mem_wdata", 64'(mem_wdata), 64'(q[0].wdata));
      check("mem_be", 64'(mem_be), 64'(q[0].be));
    end
  endtask

  // One cycle: check current outputs, drive inputs, advance the model, cross the edge.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                      input int sz, input bit sgn, input bit mr);
    bit accept;
    bit deq;
    compare_outputs();
    req_valid  = v;
    req_addr   = a;
    req_data   = d;
    req_size   = 2'(sz);
    req_signed = sgn;
    mem_ready  = mr;
    accept = v && (q.size() != DEPTH);
    deq    = (q.size() != 0) && mr;
    if (deq) void'(q.pop_front());
    exp_trunc = 1'b0;
    exp_mis   = 1'b0;
    if (accept) begin
      if (model_legal(sz, a)) begin
        q.push_back(model_entry(sz, a, d));
        exp_trunc = !model_lossless(sz, sgn, d);
      end else begin
        exp_mis = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input bit mr);
    step(1'b0, 32'h0, 32'h0, 0, 1'b0, mr);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_mem_valid"}, 64'(mem_valid), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_mem_be"}, 64'(mem_be), 64'd0);
    check({tag, "_trunc"}, 64'(trunc_err), 64'd0);
    check({tag, "_misalign"}, 64'(misalign_err), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          sz;

    #1;
    check_reset_state("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Byte signed, lossless then lossy.
    step(1'b1, 32'h1003, 32'hFFFF_FF80, 0, 1'b1, 1'b1);
    check("byte_addr", 64'(mem_addr), 64'h1000);
    check("byte_wdata", 64'(mem_wdata), 64'h8080_8080);
    check("byte_be", 64'(mem_be), 64'h8);
    check("byte_trunc0", 64'(trunc_err), 64'd0);
    step(1'b1, 32'h1003, 32'h0000_0180, 0, 1'b1, 1'b1);
    check("byte2_wdata", 64'(mem_wdata), 64'h8080_8080);
    check("byte2_trunc1", 64'(trunc_err), 64'd1);

    // Half unsigned, lossy at aligned address, then a misaligned half.
    step(1'b1, 32'h2002, 32'h0001_ABCD, 1, 1'b0, 1'b1);
    check("half_be", 64'(mem_be), 64'hC);
    check("half_wdata", 64'(mem_wdata), 64'hABCD_ABCD);
    check("half_trunc", 64'(trunc_err), 64'd1);
    idle(1'b1);
    check("half_drained", 64'(count), 64'd0);
    step(1'b1, 32'h2001, 32'h0000_1234, 1, 1'b0, 1'b0);
    check("mis_pulse", 64'(misalign_err), 64'd1);
    check("mis_count", 64'(count), 64'd0);
    check("mis_no_trunc", 64'(trunc_err), 64'd0);
    idle(1'b0);
    check("mis_pulse_end", 64'(misalign_err), 64'd0);

    // Backpressure: fill, hold a 5th, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h3000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 2, 1'b0, 1'b0);
    check("full_count", 64'(count), 64'd4);
    check("full_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h4000, 32'hDEAD_BEEF, 2, 1'b0, 1'b0);
    check("stall_wdata", 64'(mem_wdata), 64'hA000_0000);
    for (int i = 0; i < 4; i++) begin
      check("drain_order", 64'(mem_wdata), 64'hA000_0000 + 64'(i));
      idle(1'b1);
    end
    check("drained", 64'(count), 64'd0);

    // Simultaneous accept and dequeue at count 2; reserved size.
    step(1'b1, 32'h5000, 32'h1111_1111, 2, 1'b0, 1'b0);
    step(1'b1, 32'h5004, 32'h2222_2222, 2, 1'b0, 1'b0);
    step(1'b1, 32'h5008, 32'h3333_3333, 2, 1'b0, 1'b1);
    check("simul_count", 64'(count), 64'd2);
    check("simul_head", 64'(mem_wdata), 64'h2222_2222);
    step(1'b1, 32'h6000 + 32'($urandom_range(0, 3)), 32'h0000_00FF, 3, 1'b0, 1'b0);
    check("rsvd_mis", 64'(misalign_err), 64'd1);
    check("rsvd_trunc", 64'(trunc_err), 64'd0);
    check("rsvd_count", 64'(count), 64'd2);

    // Asynchronous reset with three entries buffered.
    step(1'b1, 32'h700C, 32'h4444_4444, 2, 1'b0, 1'b0);
    check("pre_rst_count", 64'(count), 64'd3);
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async");
    q.delete();
    exp_trunc = 1'b0;
    exp_mis   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("held");
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      a  = $urandom;
      d  = $urandom;
      sz = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: d = {{24{d[7]}}, d[7:0]};
        1: d = {16'h0, d[15:0]};
        2: d = {{16{d[15]}}, d[15:0]};
        default: ;
      endcase
      step($urandom_range(0, 9) < 7, a, d, sz, 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    compare_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
